// File: rtl/cmp_operand_gen.sv
// Operand-pair generator: turns a requested relation (EQ/LT/GT) into an
// A/B pair drawn from a maximal-length LFSR, with valid/ready on both sides.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   Req_valid/Req_ready  request handshake, Req_rel = 00 EQ, 01 LT, 10 GT
//   Out_valid/Out_ready  result handshake carrying A, B, Rel_out
//   Err                  one-cycle pulse when the reserved code 11 is taken
//   Count                pairs delivered since reset (wraps)
module cmp_operand_gen #(
  parameter int          WIDTH = 8,
  parameter logic [15:0] SEED  = 16'h00A5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Req_valid,
  output logic             Req_ready,
  input  logic [1:0]       Req_rel,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [1:0]       Rel_out,
  output logic             Err,
  output logic [15:0]      Count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GEN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [1:0] REL_EQ = 2'b00;
  localparam logic [1:0] REL_LT = 2'b01;
  localparam logic [1:0] REL_GT = 2'b10;

  // Feedback masks for a left-shifting Fibonacci LFSR, bit i = tap i+1.
  function automatic logic [15:0] tap_mask(input int w);
    logic [15:0] m;
    case (w)
      2:       m = 16'h0003;
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0003;
    endcase
    return m;
  endfunction

  localparam logic [15:0] TAPS_FULL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS = TAPS_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [WIDTH-1:0] LFSR_INIT =
    (SEED_W == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED_W;

  function automatic logic [WIDTH-1:0] lfsr_step(
    input logic [WIDTH-1:0] r
  );
    return {r[WIDTH-2:0], ^(r & TAPS)};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [1:0]       rel_q, rel_d;
  logic [1:0]       rel_out_q, rel_out_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [15:0]      count_q, count_d;

  logic [WIDTH-1:0] lfsr_s;
  logic [WIDTH-1:0] lfsr_ss;
  logic [WIDTH-1:0] v_min;
  logic [WIDTH-1:0] v_max;
  logic             r_lt_s;

  assign lfsr_s  = lfsr_step(lfsr_q);
  assign lfsr_ss = lfsr_step(lfsr_s);
  assign r_lt_s  = lfsr_q < lfsr_s;
  assign v_min   = r_lt_s ? lfsr_q : lfsr_s;
  assign v_max   = r_lt_s ? lfsr_s : lfsr_q;

  always_comb begin
    state_d   = state_q;
    rel_d     = rel_q;
    rel_out_d = rel_out_q;
    lfsr_d    = lfsr_q;
    a_d       = a_q;
    b_d       = b_q;
    count_d   = count_q;
    unique case (1'b1)
      state_q == IDLE: begin
        if (Req_valid) begin
          rel_d   = Req_rel;
          state_d = GEN;
        end
      end
      state_q == GEN: begin
        state_d   = HOLD;
        rel_out_d = rel_q;
        case (rel_q)
          REL_EQ: begin
            a_d = lfsr_q;
            b_d = lfsr_q;
          end
          REL_LT: begin
            a_d = v_min;
            b_d = v_max;
          end
          REL_GT: begin
            a_d = v_max;
            b_d = v_min;
          end
          default: begin
            state_d   = IDLE;
            rel_out_d = rel_out_q;
          end
        endcase
      end
      state_q == HOLD: begin
        if (Out_ready) begin
          // Both R and S were consumed, so skip past both.
          count_d = count_q + 16'd1;
          lfsr_d  = lfsr_ss;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rel_q     <= 2'b00;
      rel_out_q <= 2'b00;
      lfsr_q    <= LFSR_INIT;
      a_q       <= '0;
      b_q       <= '0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      rel_q     <= rel_d;
      rel_out_q <= rel_out_d;
      lfsr_q    <= lfsr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      count_q   <= count_d;
    end
  end

  assign Req_ready = state_q == IDLE;
  assign Out_valid = state_q == HOLD;
  assign Err       = (state_q == GEN) && (rel_q == 2'b11);
  assign A         = a_q;
  assign B         = b_q;
  assign Rel_out   = rel_out_q;
  assign Count     = count_q;

endmodule

// File: tb/tb_cmp_operand_gen.sv
// Directed bench for cmp_operand_gen: reset, EQ/LT/GT pairs, Err,
// stalls, reset abort, Count wrap, zero seed and WIDTH=2.
module tb_cmp_operand_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_rel = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  a, b;
  logic [1:0]  rel_out;
  logic        err;
  logic [15:0] count;

  logic        z_req_valid = 1'b0;
  logic        z_req_ready;
  logic [1:0]  z_req_rel = 2'b00;
  logic        z_out_valid;
  logic        z_out_ready = 1'b0;
  logic [7:0]  z_a, z_b;
  logic [1:0]  z_rel_out;
  logic        z_err;
  logic [15:0] z_count;

  logic        n_req_valid = 1'b0;
  logic        n_req_ready;
  logic [1:0]  n_req_rel = 2'b00;
  logic        n_out_valid;
  logic        n_out_ready = 1'b0;
  logic [1:0]  n_a, n_b;
  logic [1:0]  n_rel_out;
  logic        n_err;
  logic [15:0] n_count;

  cmp_operand_gen #(.WIDTH(8), .SEED(16'h00A5)) dut (
    .clk(clk), .rst(rst),
    .Req_valid(req_valid), .Req_ready(req_ready), .Req_rel(req_rel),
    .Out_valid(out_valid), .Out_ready(out_ready),
    .A(a), .B(b), .Rel_out(rel_out), .Err(err), .Count(count)
  );

  cmp_operand_gen #(.WIDTH(8), .SEED(16'h0000)) dut_z (
    .clk(clk), .rst(rst),
    .Req_valid(z_req_valid), .Req_ready(z_req_ready),
    .Req_rel(z_req_rel),
    .Out_valid(z_out_valid), .Out_ready(z_out_ready),
    .A(z_a), .B(z_b), .Rel_out(z_rel_out), .Err(z_err),
    .Count(z_count)
  );

  cmp_operand_gen #(.WIDTH(2), .SEED(16'h00A5)) dut_n (
    .clk(clk), .rst(rst),
    .Req_valid(n_req_valid), .Req_ready(n_req_ready),
    .Req_rel(n_req_rel),
    .Out_valid(n_out_valid), .Out_ready(n_out_ready),
    .A(n_a), .B(n_b), .Rel_out(n_rel_out), .Err(n_err),
    .Count(n_count)
  );

  // Called at a negedge; returns at the negedge of the GEN cycle.
  task automatic drive_req(input logic [1:0] rel);
    int n;
    req_valid = 1'b1;
    req_rel   = rel;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL req_timeout ready=%b required=1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl ready=%b valid=%b err=%b required=1/0/0",
               req_ready, out_valid, err);
    end
    checks++;
    if (a !== 8'h00 || b !== 8'h00 || rel_out !== 2'b00) begin
      failures++;
      $display("FAIL reset_data a=%h b=%h rel=%b required=00/00/00",
               a, b, rel_out);
    end
    checks++;
    if (count !== 16'h0000) begin
      failures++;
      $display("FAIL reset_count count=%h required=0000", count);
    end
    rst = 1'b0;
  endtask

  task automatic test_eq_first();
    out_ready = 1'b1;
    drive_req(2'b00);
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL eq_gen valid=%b err=%b required=0/0",
               out_valid, err);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || a !== 8'hA5 || b !== 8'hA5 ||
        rel_out !== 2'b00) begin
      failures++;
      $display("FAIL eq_first valid=%b a=%h b=%h rel=%b required=1/a5/a5/00",
               out_valid, a, b, rel_out);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || count !== 16'd1 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL eq_done valid=%b count=%h ready=%b required=0/0001/1",
               out_valid, count, req_ready);
    end
  endtask

  task automatic test_err();
    drive_req(2'b11);
    checks++;
    if (err !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse err=%b valid=%b required=1/0", err, out_valid);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b1 ||
        count !== 16'd1 || a !== 8'hA5) begin
      failures++;
      $display("FAIL err_after err=%b valid=%b ready=%b count=%h a=%h required=0/0/1/0001/a5",
               err, out_valid, req_ready, count, a);
    end
    drive_req(2'b00);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || a !== 8'h95 || b !== 8'h95) begin
      failures++;
      $display("FAIL err_next valid=%b a=%h b=%h required=1/95/95",
               out_valid, a, b);
    end
    @(negedge clk);
    drive_req(2'b01);
    @(negedge clk);
    checks++;
    if (a !== 8'h54 || b !== 8'hA9 || rel_out !== 2'b01) begin
      failures++;
      $display("FAIL lt_pair a=%h b=%h rel=%b required=54/a9/01",
               a, b, rel_out);
    end
    @(negedge clk);
    drive_req(2'b10);
    @(negedge clk);
    checks++;
    if (a !== 8'hA7 || b !== 8'h53 || rel_out !== 2'b10) begin
      failures++;
      $display("FAIL gt_pair a=%h b=%h rel=%b required=a7/53/10",
               a, b, rel_out);
    end
    @(negedge clk);
    checks++;
    if (count !== 16'd4) begin
      failures++;
      $display("FAIL count_4 count=%h required=0004", count);
    end
  endtask

  task automatic test_back_to_back();
    int nv;
    int nr;
    nv = 0;
    nr = 0;
    out_ready = 1'b1;
    req_valid = 1'b1;
    req_rel   = 2'b00;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
      if (req_ready) nr++;
    end
    req_valid = 1'b0;
    checks++;
    if (nv != 3 || nr != 3) begin
      failures++;
      $display("FAIL b2b valid_cycles=%0d ready_cycles=%0d required=3/3",
               nv, nr);
    end
    checks++;
    if (count !== 16'd7) begin
      failures++;
      $display("FAIL b2b_count count=%h required=0007", count);
    end
  endtask

  task automatic test_stall_reset();
    logic [7:0] a0;
    logic [7:0] b0;
    out_ready = 1'b0;
    drive_req(2'b01);
    @(negedge clk);
    a0 = a;
    b0 = b;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || a !== a0 || b !== b0) begin
        failures++;
        $display("FAIL stall_hold valid=%b a=%h b=%h required=1/%h/%h",
                 out_valid, a, b, a0, b0);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 16'd0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort valid=%b count=%h ready=%b required=0/0000/1",
               out_valid, count, req_ready);
    end
    out_ready = 1'b1;
    drive_req(2'b00);
    @(negedge clk);
    checks++;
    if (a !== 8'hA5 || b !== 8'hA5) begin
      failures++;
      $display("FAIL reseed a=%h b=%h required=a5/a5", a, b);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0] rel;
    logic [7:0] a0;
    logic [7:0] b0;
    logic       ok;
    int         k;
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      rel = 2'($urandom_range(0, 2));
      out_ready = 1'($urandom_range(0, 1));
      drive_req(rel);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      a0 = a;
      b0 = b;
      case (rel)
        2'b00:   ok = (a == b);
        2'b01:   ok = (a < b);
        default: ok = (a > b);
      endcase
      checks++;
      if (out_valid !== 1'b1 || !ok || a == 8'h00 || b == 8'h00 ||
          rel_out !== rel) begin
        failures++;
        $display("FAIL rand_pair n=%0d valid=%b a=%h b=%h rel_out=%b required=1/rel %b/nonzero",
                 n, out_valid, a, b, rel_out, rel);
      end
      k = 0;
      while (out_valid && k < 40) begin
        out_ready = (k >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        k++;
        if (out_valid) begin
          checks++;
          if (a !== a0 || b !== b0 || rel_out !== rel) begin
            failures++;
            $display("FAIL rand_stable n=%0d a=%h b=%h required=%h/%h",
                     n, a, b, a0, b0);
          end
        end
      end
    end
    checks++;
    if (count !== 16'd1000) begin
      failures++;
      $display("FAIL rand_count count=%0d required=1000", count);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b0;
    drive_req(2'b00);
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    checks++;
    if (count !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_set count=%h required=ffff", count);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (count !== 16'h0000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap count=%h valid=%b required=0000/0", count, out_valid);
    end
  endtask

  task automatic test_seed0();
    do_reset();
    z_out_ready = 1'b1;
    z_req_rel   = 2'b00;
    z_req_valid = 1'b1;
    @(negedge clk);
    z_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (z_out_valid !== 1'b1 || z_a !== 8'h01 || z_b !== 8'h01) begin
      failures++;
      $display("FAIL seed0 valid=%b a=%h b=%h required=1/01/01",
               z_out_valid, z_a, z_b);
    end
    @(negedge clk);
    checks++;
    if (z_count !== 16'd1) begin
      failures++;
      $display("FAIL seed0_count count=%h required=0001", z_count);
    end
  endtask

  task automatic test_width2();
    logic [1:0] ea [3];
    logic [1:0] eb [3];
    ea[0] = 2'd1; eb[0] = 2'd3;
    ea[1] = 2'd1; eb[1] = 2'd2;
    ea[2] = 2'd2; eb[2] = 2'd3;
    do_reset();
    n_out_ready = 1'b1;
    n_req_rel   = 2'b01;
    for (int r = 0; r < 6; r++) begin
      n_req_valid = 1'b1;
      @(negedge clk);
      n_req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (n_out_valid !== 1'b1 || n_a !== ea[r % 3] ||
          n_b !== eb[r % 3] || !(n_a < n_b)) begin
        failures++;
        $display("FAIL w2_lt r=%0d valid=%b a=%0d b=%0d required=1/%0d/%0d",
                 r, n_out_valid, n_a, n_b, ea[r % 3], eb[r % 3]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_eq_first();
    test_err();
    test_back_to_back();
    test_stall_reset();
    test_wrap();
    test_random();
    test_seed0();
    test_width2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
